irrigation_sequencer: RTL

//  Multi-zone successor to the single-zone 4-state irrigation FSM. Per zone: Fill -> Sprinkle and/or Drip -> Clean.

---
 rtl/irrigation_pkg.sv | 42 ++++
 rtl/phase_timer.sv | 48 ++++
 rtl/irrigation_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/irrigation_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irrigation_pkg
//  Description : Shared phase codes and zone-mode constants for the
//                multi-zone irrigation sequencer.
//  Contents    : state_t  - 3-bit phase code driven on the sequencer's
//                           state output
//                MODE_*   - per-zone watering mode encodings {R1,R0}
//                mode_*() - helpers that decode which watering phases a
//                           mode contains
//  Revision    : 1.0  initial release
// ============================================================================
package irrigation_pkg;

    // Phase codes. These values appear on the state port, so they are fixed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_SELECT   = 3'b001,
        ST_FILL     = 3'b010,
        ST_SPRINKLE = 3'b011,
        ST_DRIP     = 3'b100,
        ST_CLEAN    = 3'b101
    } state_t;

    // Zone modes: N none, A sprinkle only, G drip only, S sprinkle then drip.
    localparam logic [1:0] MODE_N = 2'b00;
    localparam logic [1:0] MODE_A = 2'b01;
    localparam logic [1:0] MODE_G = 2'b10;
    localparam logic [1:0] MODE_S = 2'b11;

    // A mode that includes a sprinkle phase (A or S).
    function automatic logic mode_has_sprinkle(input logic [1:0] mode);
        return (mode == MODE_A) || (mode == MODE_S);
    endfunction

    // A mode that includes a drip phase (G or S).
    function automatic logic mode_has_drip(input logic [1:0] mode);
        return (mode == MODE_G) || (mode == MODE_S);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Tick-driven down-counter that times a single phase.
//                A load sets the count to the requested duration, with a
//                duration of 0 treated as 1. Each tick decrements the count.
//                time_over is asserted combinationally in the cycle where
//                the count is 1 and a tick is present, so the phase lasts
//                exactly 'value' ticks.
//  Ports       : clock     in  system clock (rising edge)
//                reset     in  synchronous active-high reset, count -> 0
//                load      in  load 'value' as the new phase duration
//                value     in  TIMER_W phase duration in ticks
//                tick      in  timebase strobe
//                time_over out last tick of the current phase
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    input  logic               tick,
    output logic               time_over
);

    localparam logic [TIMER_W-1:0] C_ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            // A zero duration would otherwise never reach 1; run it as 1 tick.
            r_count <= (value == '0) ? C_ONE : value;
        end else if (tick && (r_count != '0)) begin
            // Saturate at 0 so an idle timer never wraps around.
            r_count <= r_count - C_ONE;
        end
    end

    assign time_over = tick && (r_count == C_ONE);

endmodule
`default_nettype wire

// File: rtl/irrigation_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : irrigation_sequencer
//  Description : Multi-zone irrigation sequencer. After a start pulse, it
//                visits zones 0..ZONES-1 in turn. Each zone runs
//                FILL -> SPRINKLE and/or DRIP -> CLEAN according to its
//                2-bit mode, and zones with mode N are skipped. Phase
//                lengths come from an internal tick-driven timer. abort
//                finishes the current zone with a CLEAN phase and then
//                returns to IDLE. All outputs are registered and decoded
//                from the phase (Moore).
//  Ports       : clock, reset        clock; synchronous active-high reset
//                tick                timebase strobe for the phase timer
//                start, abort        control pulses
//                zone_mode           2 bits per zone, zone i at [2i+1:2i]
//                dur_fill/sprinkle/drip/clean  phase lengths in ticks
//                state, zone         current phase code and zone index
//                pump, sprinkler_v,
//                drip_v, flush_v     actuators for FILL/SPRINKLE/DRIP/CLEAN
//                busy                any phase other than IDLE
//                done                1-cycle pulse on return to IDLE after
//                                    a full pass or an abort
//  Revision    : 1.0  initial release
// ============================================================================
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int ZONES   = 4,
    parameter int TIMER_W = 16,
    parameter int ZIDX_W  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2*ZONES-1:0]   zone_mode,
    input  logic [TIMER_W-1:0]   dur_fill,
    input  logic [TIMER_W-1:0]   dur_sprinkle,
    input  logic [TIMER_W-1:0]   dur_drip,
    input  logic [TIMER_W-1:0]   dur_clean,
    output logic [2:0]           state,
    output logic [ZIDX_W-1:0]    zone,
    output logic                 pump,
    output logic                 sprinkler_v,
    output logic                 drip_v,
    output logic                 flush_v,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ZIDX_W-1:0] C_LAST_ZONE = ZIDX_W'(ZONES - 1);
    localparam logic [ZIDX_W-1:0] C_ZONE_ONE  = ZIDX_W'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [ZIDX_W-1:0]   r_zone;
    logic [1:0]          r_mode;     // mode of the active zone, frozen in SELECT
    logic                r_abort;    // abort seen: end after this zone's CLEAN
    logic                r_pump;
    logic                r_sprinkler;
    logic                r_drip;
    logic                r_flush;
    logic                r_busy;
    logic                r_done;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t              w_next_state;
    logic [ZIDX_W-1:0]   w_next_zone;
    logic [1:0]          w_next_mode;
    logic                w_next_abort;
    logic                w_done;
    logic                w_load;
    logic [TIMER_W-1:0]  w_load_val;
    logic [1:0]          w_sel_mode;
    logic                w_time_over;

    // ------------------------------------------------------------------
    // Phase timer: loaded on entry to every timed phase
    // ------------------------------------------------------------------
    phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_phase_timer (
        .clock     (clock),
        .reset     (reset),
        .load      (w_load),
        .value     (w_load_val),
        .tick      (tick),
        .time_over (w_time_over)
    );

    // Mode of the zone currently addressed, taken straight from the config
    // bus. It is only used in SELECT, where it is also captured in r_mode.
    always_comb begin
        w_sel_mode = MODE_N;
        for (int i = 0; i < ZONES; i++) begin
            if (r_zone == ZIDX_W'(i)) begin
                w_sel_mode = zone_mode[2*i +: 2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_zone  = r_zone;
        w_next_mode  = r_mode;
        w_next_abort = r_abort;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_load_val   = dur_fill;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_SELECT;
                    w_next_zone  = '0;
                    w_next_abort = 1'b0;
                end
            end

            ST_SELECT: begin
                w_next_mode = w_sel_mode;
                if (abort) begin
                    w_next_state = ST_IDLE;
                    w_next_zone  = '0;
                    w_done       = 1'b1;
                end else if (w_sel_mode == MODE_N) begin
                    // Skipped zone: no phases run, so no CLEAN either.
                    if (r_zone == C_LAST_ZONE) begin
                        w_next_state = ST_IDLE;
                        w_next_zone  = '0;
                        w_done       = 1'b1;
                    end else begin
                        w_next_zone  = r_zone + C_ZONE_ONE;
                    end
                end else begin
                    w_next_state = ST_FILL;
                    w_load       = 1'b1;
                    w_load_val   = dur_fill;
                end
            end

            ST_FILL, ST_SPRINKLE, ST_DRIP: begin
                // abort overrides a phase that would end this same cycle.
                if (abort) begin
                    w_next_state = ST_CLEAN;
                    w_next_abort = 1'b1;
                    w_load       = 1'b1;
                    w_load_val   = dur_clean;
                end else if (w_time_over) begin
                    w_load = 1'b1;
                    if ((r_state == ST_FILL) && mode_has_sprinkle(r_mode)) begin
                        w_next_state = ST_SPRINKLE;
                        w_load_val   = dur_sprinkle;
                    end else if ((r_state != ST_DRIP) && mode_has_drip(r_mode)) begin
                        // FILL of a G zone, or SPRINKLE of an S zone.
                        w_next_state = ST_DRIP;
                        w_load_val   = dur_drip;
                    end else begin
                        w_next_state = ST_CLEAN;
                        w_load_val   = dur_clean;
                    end
                end
            end

            ST_CLEAN: begin
                // The clean cycle always completes; abort only ends the pass.
                if (abort) begin
                    w_next_abort = 1'b1;
                end
                if (w_time_over) begin
                    if (r_abort || abort || (r_zone == C_LAST_ZONE)) begin
                        w_next_state = ST_IDLE;
                        w_next_zone  = '0;
                        w_next_abort = 1'b0;
                        w_done       = 1'b1;
                    end else begin
                        w_next_state = ST_SELECT;
                        w_next_zone  = r_zone + C_ZONE_ONE;
                    end
                end
            end

            default: begin
                w_next_state = ST_IDLE;
                w_next_zone  = '0;
                w_next_abort = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next phase
    // so they change on the same edge as the phase they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_zone      <= '0;
            r_mode      <= MODE_N;
            r_abort     <= 1'b0;
            r_pump      <= 1'b0;
            r_sprinkler <= 1'b0;
            r_drip      <= 1'b0;
            r_flush     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_zone      <= w_next_zone;
            r_mode      <= w_next_mode;
            r_abort     <= w_next_abort;
            r_pump      <= (w_next_state == ST_FILL);
            r_sprinkler <= (w_next_state == ST_SPRINKLE);
            r_drip      <= (w_next_state == ST_DRIP);
            r_flush     <= (w_next_state == ST_CLEAN);
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= w_done;
        end
    end

    assign state       = r_state;
    assign zone        = r_zone;
    assign pump        = r_pump;
    assign sprinkler_v = r_sprinkler;
    assign drip_v      = r_drip;
    assign flush_v     = r_flush;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire
